// File: rtl/mcpu_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: state encodings,
// opcode/funct values, ALU operation codes, datapath mux selects and the
// control bundle passed from the decoder to the top level.
package mcpu_pkg;

    // State encodings (values are visible on the State port)
    localparam logic [5:0] S_IF     = 6'd0;
    localparam logic [5:0] S_ID     = 6'd1;
    localparam logic [5:0] S_EXE_R  = 6'd2;
    localparam logic [5:0] S_EXE_I  = 6'd3;
    localparam logic [5:0] S_ADDR   = 6'd4;
    localparam logic [5:0] S_MEM_LW = 6'd5;
    localparam logic [5:0] S_MEM_SW = 6'd6;
    localparam logic [5:0] S_WB_R   = 6'd7;
    localparam logic [5:0] S_WB_I   = 6'd8;
    localparam logic [5:0] S_WB_LW  = 6'd9;
    localparam logic [5:0] S_BR     = 6'd10;
    localparam logic [5:0] S_JMP    = 6'd11;
    localparam logic [5:0] S_ILL    = 6'd63;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    // True for the five supported R-type functions
    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    // ALU operation for an R-type funct; unsupported functs fall back to ADD
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            FN_ADD:  a = ALU_ADD;
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Moore control decoder: maps the current state (plus Op/Zero in the branch
// state and Mem_Ready in fetch) onto the datapath control bundle. While reset
// is held every write strobe is forced low so nothing in the datapath moves.
module mcpu_ctrl_decode
    import mcpu_pkg::*;
(
    input  logic [5:0] state,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       rst,
    output ctrl_t      ctrl
);

    // Per-state control decode with everything defaulting to 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_ID: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            S_EXE_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_ctrl  = funct_alu(func);
            end
            S_EXE_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = (op == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            S_MEM_LW: begin
                ctrl.iord = 1'b1;
            end
            S_MEM_SW: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_WB_I: begin
                ctrl.reg_write = 1'b1;
            end
            S_WB_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_BR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = ((op == OP_BEQ) &&  zero) ||
                                 ((op == OP_BNE) && !zero);
            end
            S_JMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (rst) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit: state register, next-state logic,
// sticky Illegal flag and retired-instruction counter. Control outputs come
// from the mcpu_ctrl_decode instance.
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int STATE_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Func,
    input  logic               Zero,
    input  logic               Mem_Ready,
    output logic [STATE_W-1:0] State,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [2:0]         ALUCtrl,
    output logic               Illegal,
    output logic [CNT_W-1:0]   InstCnt
);

    logic [5:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic             retire;
    ctrl_t            ctrl;

    // State, flag and counter registers; reset wins over everything
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IF;
            illegal_q  <= 1'b0;
            inst_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    // Next-state selection; unused encodings fall back to fetch
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:     state_d = Mem_Ready ? S_ID : S_IF;
            S_ID: begin
                case (Op)
                    OP_RTYPE:        state_d = S_EXE_R;
                    OP_ADDI, OP_ORI: state_d = S_EXE_I;
                    OP_LW, OP_SW:    state_d = S_ADDR;
                    OP_BEQ, OP_BNE:  state_d = S_BR;
                    OP_J:            state_d = S_JMP;
                    default:         state_d = S_ILL;
                endcase
            end
            S_EXE_R:  state_d = funct_legal(Func) ? S_WB_R : S_ILL;
            S_EXE_I:  state_d = S_WB_I;
            S_ADDR:   state_d = (Op == OP_LW) ? S_MEM_LW : S_MEM_SW;
            S_MEM_LW: state_d = Mem_Ready ? S_WB_LW : S_MEM_LW;
            S_MEM_SW: state_d = Mem_Ready ? S_IF : S_MEM_SW;
            S_WB_R, S_WB_I, S_WB_LW, S_BR, S_JMP: state_d = S_IF;
            S_ILL:    state_d = S_ILL;
            default:  state_d = S_IF;
        endcase
    end

    // Retirement counting and sticky illegal detection
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_WB_R, S_WB_I, S_WB_LW, S_BR, S_JMP: retire = 1'b1;
            S_MEM_SW:                             retire = Mem_Ready;
            default:                              retire = 1'b0;
        endcase
        inst_cnt_d = inst_cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));
        illegal_d  = illegal_q | (state_d == S_ILL);
    end

    mcpu_ctrl_decode u_decode (
        .state     (state_q),
        .op        (Op),
        .func      (Func),
        .zero      (Zero),
        .mem_ready (Mem_Ready),
        .rst       (Rst),
        .ctrl      (ctrl)
    );

    assign State    = STATE_W'(state_q);
    assign PCWrite  = ctrl.pc_write;
    assign IRWrite  = ctrl.ir_write;
    assign IorD     = ctrl.iord;
    assign MemWrite = ctrl.mem_write;
    assign RegWrite = ctrl.reg_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign PCSource = ctrl.pc_source;
    assign ALUCtrl  = ctrl.alu_ctrl;
    assign Illegal  = illegal_q;
    assign InstCnt  = inst_cnt_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: directed instruction sequences with literal
// expectations, plus an instruction-level reference model checked every cycle.
module tb_mcpu_ctrl_fsm;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [5:0]  Op, Func;
    logic        Zero, Mem_Ready;
    logic [5:0]  State;
    logic        PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUCtrl;
    logic        Illegal;
    logic [31:0] InstCnt;
    logic [14:0] dut_ctrl;

    mcpu_ctrl_fsm #(.STATE_W(6), .CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .State(State), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUCtrl(ALUCtrl),
        .Illegal(Illegal), .InstCnt(InstCnt)
    );

    always #5 Clk = ~Clk;

    assign dut_ctrl = {PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, MemtoReg,
                       ALUSrcA, ALUSrcB, PCSource, ALUCtrl};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    // Dispatch target per opcode and ALU code per funct, straight from the ISA table.
    int dispatch[int];
    int alu_of_fn[int];
    int m_st = 0;
    int m_nx;
    logic [31:0] m_cnt = '0;
    bit  m_ill = 1'b0;
    bit  m_on  = 1'b0;
    bit  m_ret;

    initial begin
        dispatch[0]  = 2;  dispatch[8]  = 3; dispatch[13] = 3;
        dispatch[35] = 4;  dispatch[43] = 4;
        dispatch[4]  = 10; dispatch[5]  = 10; dispatch[2] = 11;
        alu_of_fn[32] = 2; alu_of_fn[34] = 6; alu_of_fn[36] = 0;
        alu_of_fn[37] = 1; alu_of_fn[42] = 7;
    end

    always @(posedge Clk) begin
        if (Rst) begin
            m_st  = 0;
            m_cnt = '0;
            m_ill = 1'b0;
            m_on  = 1'b1;
        end else if (m_on) begin
            m_ret = (m_st >= 7 && m_st <= 11) || (m_st == 6 && Mem_Ready);
            case (m_st)
                0:  m_nx = Mem_Ready ? 1 : 0;
                1:  m_nx = dispatch.exists(int'(Op)) ? dispatch[int'(Op)] : 63;
                2:  m_nx = alu_of_fn.exists(int'(Func)) ? 7 : 63;
                3:  m_nx = 8;
                4:  m_nx = (Op == 6'd35) ? 5 : 6;
                5:  m_nx = Mem_Ready ? 9 : 5;
                6:  m_nx = Mem_Ready ? 0 : 6;
                63: m_nx = 63;
                default: m_nx = 0;
            endcase
            if (m_ret) m_cnt = m_cnt + 1;
            m_st = m_nx;
            if (m_nx == 63) m_ill = 1'b1;
        end
    end

    function automatic logic [14:0] exp_ctrl(input int st);
        bit pcw, irw, iord, mw, rw, rd, m2r, sa;
        bit [1:0] sb, ps;
        bit [2:0] alu;
        {pcw, irw, iord, mw, rw, rd, m2r, sa, sb, ps, alu} = '0;
        case (st)
            0:  begin sb = 2'd1; alu = 3'b010; pcw = Mem_Ready; irw = Mem_Ready; end
            1:  begin sb = 2'd3; alu = 3'b010; end
            2:  begin sa = 1; alu = alu_of_fn.exists(int'(Func)) ? 3'(alu_of_fn[int'(Func)]) : 3'b010; end
            3:  begin sa = 1; sb = 2'd2; alu = (Op == 6'd13) ? 3'b001 : 3'b010; end
            4:  begin sa = 1; sb = 2'd2; alu = 3'b010; end
            5:  iord = 1;
            6:  begin iord = 1; mw = 1; end
            7:  begin rw = 1; rd = 1; end
            8:  rw = 1;
            9:  begin rw = 1; m2r = 1; end
            10: begin sa = 1; alu = 3'b110; ps = 2'd1;
                      pcw = (Op == 6'd4 && Zero) || (Op == 6'd5 && !Zero); end
            11: begin ps = 2'd2; pcw = 1; end
            default: ;
        endcase
        if (Rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
        return {pcw, irw, iord, mw, rw, rd, m2r, sa, sb, ps, alu};
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge Clk) begin
        if (m_on) begin
            chk("model_state",   64'(State),    64'(m_st));
            chk("model_ctrl",    64'(dut_ctrl), 64'(exp_ctrl(m_st)));
            chk("model_instcnt", 64'(InstCnt),  64'(m_cnt));
            chk("model_illegal", 64'(Illegal),  64'(m_ill));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         lat;
    } instr_t;

    instr_t prog[9] = '{
        '{6'b001101, 6'd0,      4},  // ori
        '{6'b001000, 6'd0,      4},  // addi
        '{6'b000000, 6'b100010, 4},  // sub
        '{6'b000000, 6'b101010, 4},  // slt
        '{6'b000000, 6'b100100, 4},  // and
        '{6'b000000, 6'b100101, 4},  // or
        '{6'b000010, 6'd0,      3},  // j
        '{6'b100011, 6'd0,      5},  // lw
        '{6'b101011, 6'd0,      4}   // sw
    };
    int rdy_seq[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};

    initial begin
        int irw_cnt, mw_cnt, ill_cnt, n;
        Rst = 1'b1;
        Op = 6'($urandom()); Func = 6'($urandom());
        Zero = 1'($urandom()); Mem_Ready = 1'($urandom());
        repeat (2) begin
            cyc();
            Op = 6'($urandom()); Func = 6'($urandom());
            Zero = 1'($urandom()); Mem_Ready = 1'($urandom());
            #1;
        end
        // 1: reset with random inputs
        chk("rst_state",   64'(State), 64'd0);
        chk("rst_strobes", 64'({PCWrite, IRWrite, MemWrite, RegWrite}), 64'd0);
        chk("rst_instcnt", 64'(InstCnt), 64'd0);
        chk("rst_illegal", 64'(Illegal), 64'd0);

        // 2: add with memory always ready
        Rst = 1'b0; Op = 6'b000000; Func = 6'b100000; Zero = 1'b0; Mem_Ready = 1'b1;
        #1;
        chk("add_s0", 64'(State), 64'd0);
        cyc(); chk("add_s1", 64'(State), 64'd1);
        cyc(); chk("add_s2", 64'(State), 64'd2);
        chk("add_alu", 64'(ALUCtrl), 64'b010);
        cyc(); chk("add_s7", 64'(State), 64'd7);
        chk("add_wb", 64'({RegWrite, RegDst, MemtoReg}), 64'b110);
        cyc(); chk("add_cnt", 64'(InstCnt), 64'd1);
        chk("add_back_if", 64'(State), 64'd0);

        // 3: lw with fetch and memory wait states
        Op = 6'b100011; irw_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            Mem_Ready = rdy_seq[i][0];
            #1;
            irw_cnt += int'(IRWrite);
            if (i == 9) begin
                chk("lw_wb_state", 64'(State), 64'd9);
                chk("lw_memtoreg", 64'(MemtoReg), 64'd1);
            end
            cyc();
        end
        chk("lw_irwrite_cycles", 64'(irw_cnt), 64'd1);
        chk("lw_cnt", 64'(InstCnt), 64'd2);
        chk("lw_back_if", 64'(State), 64'd0);

        // 4: beq taken, bne not taken, both with Zero = 1
        Mem_Ready = 1'b1; Zero = 1'b1; Op = 6'b000100;
        cyc(); cyc();
        chk("beq_state", 64'(State), 64'd10);
        chk("beq_pcwrite", 64'(PCWrite), 64'd1);
        chk("beq_pcsource", 64'(PCSource), 64'b01);
        cyc();
        Op = 6'b000101;
        cyc(); cyc();
        chk("bne_state", 64'(State), 64'd10);
        chk("bne_pcwrite", 64'(PCWrite), 64'd0);
        cyc();
        chk("br_cnt", 64'(InstCnt), 64'd4);

        // Remaining instruction classes with their latencies
        Zero = 1'b0;
        foreach (prog[k]) begin
            Op = prog[k].op; Func = prog[k].fn;
            n = 0;
            do begin cyc(); n++; end while (State != 6'd0 && n < 12);
            chk($sformatf("lat_op%0h_fn%0h", prog[k].op, prog[k].fn), 64'(n), 64'(prog[k].lat));
        end
        chk("prog_cnt", 64'(InstCnt), 64'd13);

        // 5: unsupported opcode is absorbing and freezes the counter
        Op = 6'b111111;
        cyc(); cyc();
        chk("ill_state", 64'(State), 64'd63);
        ill_cnt = 0;
        repeat (20) begin
            cyc();
            if (Illegal === 1'b1 && State == 6'd63) ill_cnt++;
        end
        chk("ill_held_cycles", 64'(ill_cnt), 64'd20);
        chk("ill_cnt_frozen", 64'(InstCnt), 64'd13);
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        #1;
        chk("ill_rst_state", 64'(State), 64'd0);
        chk("ill_rst_flag", 64'(Illegal), 64'd0);
        chk("ill_rst_cnt", 64'(InstCnt), 64'd0);

        // Unsupported R-type funct also traps
        Op = 6'b000000; Func = 6'b111111;
        cyc(); cyc(); cyc();
        chk("badfn_state", 64'(State), 64'd63);
        chk("badfn_flag", 64'(Illegal), 64'd1);
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;

        // 6: reset while a store waits on memory
        Op = 6'b101011; Func = 6'd0; Mem_Ready = 1'b1;
        cyc(); cyc(); cyc();
        Mem_Ready = 1'b0;
        #1;
        chk("sw_wait_state", 64'(State), 64'd6);
        chk("sw_wait_memwrite", 64'(MemWrite), 64'd1);
        Rst = 1'b1;
        #1;
        chk("sw_rst_memwrite", 64'(MemWrite), 64'd0);
        cyc();
        Rst = 1'b0;
        #1;
        chk("sw_rst_state", 64'(State), 64'd0);
        chk("sw_rst_after_memwrite", 64'(MemWrite), 64'd0);
        chk("sw_rst_cnt", 64'(InstCnt), 64'd0);

        // sw with memory ready: one write strobe cycle
        Mem_Ready = 1'b1; mw_cnt = 0;
        repeat (4) begin
            #1;
            mw_cnt += int'(MemWrite);
            cyc();
        end
        chk("sw_memwrite_cycles", 64'(mw_cnt), 64'd1);
        chk("sw_cnt", 64'(InstCnt), 64'd1);
        chk("sw_back_if", 64'(State), 64'd0);

        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
